// File: rtl/timer_state_ctrl.sv
// Button-driven timer-select FSM: each press steps OFF->T1->T2->T3->OFF,
// and each active state counts down its duration in seconds before dropping to OFF.
module timer_state_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned T1_SEC   = 3,
  parameter int unsigned T2_SEC   = 5,
  parameter int unsigned T3_SEC   = 7,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_btn,
  input  logic             i_clear,
  output logic [1:0]       o_time_state,
  output logic [2:0]       o_time,
  output logic [CNT_W-1:0] o_remain_sec,
  output logic             o_expire
);

  localparam int unsigned    PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF = 2'b00,
    ST_T1  = 2'b01,
    ST_T2  = 2'b10,
    ST_T3  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             expire_q, expire_d;

  // i_btn and i_clear are single-cycle qualifiers sampled every edge; no backpressure.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_OFF;
      presc_q  <= '0;
      remain_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    expire_d = 1'b0;
    if (i_clear) begin
      state_d  = ST_OFF;
      presc_d  = '0;
      remain_d = '0;
    end else if (i_btn) begin
      // A press out of T3 lands in OFF silently; expiry only comes from the countdown.
      state_d = state_t'(state_q + 2'd1);
      presc_d = '0;
      case (state_d)
        ST_T1:   remain_d = CNT_W'(T1_SEC);
        ST_T2:   remain_d = CNT_W'(T2_SEC);
        ST_T3:   remain_d = CNT_W'(T3_SEC);
        default: remain_d = '0;
      endcase
    end else if (state_q != ST_OFF) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (remain_q <= CNT_W'(1)) begin
          remain_d = '0;
          state_d  = ST_OFF;
          expire_d = 1'b1;
        end else begin
          remain_d = remain_q - CNT_W'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d  = '0;
      remain_d = '0;
    end
  end

  always_comb begin
    o_time = 3'b000;
    case (state_q)
      ST_T1:   o_time = 3'b001;
      ST_T2:   o_time = 3'b010;
      ST_T3:   o_time = 3'b100;
      default: o_time = 3'b000;
    endcase
  end

  assign o_time_state = state_q;
  assign o_remain_sec = remain_q;
  assign o_expire     = expire_q;

endmodule
